// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and widths for the program-counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_PREV = 3'd1,
        OP_JF   = 3'd2,
        OP_JB   = 3'd3,
        OP_JZF  = 3'd4,
        OP_JZB  = 3'd5,
        OP_JNZF = 3'd6,
        OP_JNZB = 3'd7
    } exec_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        HALT  = 3'd3,
        FAULT = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next_calc.sv
// ============================================================================
// Module      : pc_next_calc
// Description : Combinational next-PC computation (step / branch, mod 256).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_calc
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  exec_op_t        op_i,
    input  logic [3:0]      v_i,
    input  logic            zero_i,
    output logic [PC_W-1:0] next_pc_o
);

    logic [PC_W-1:0] w_dist;
    logic [PC_W-1:0] w_step;
    logic            w_back;

    assign w_dist = {3'b000, v_i, 1'b0};

    // Every op reduces to a magnitude and a direction; untaken branches fall back to +1.
    always_comb begin
        w_step = 8'd1;
        w_back = 1'b0;
        case (op_i)
            OP_NEXT: begin w_step = 8'd1;  w_back = 1'b0; end
            OP_PREV: begin w_step = 8'd1;  w_back = 1'b1; end
            OP_JF:   begin w_step = w_dist; w_back = 1'b0; end
            OP_JB:   begin w_step = w_dist; w_back = 1'b1; end
            OP_JZF:  begin w_step = zero_i ? w_dist : 8'd1; w_back = 1'b0;   end
            OP_JZB:  begin w_step = zero_i ? w_dist : 8'd1; w_back = zero_i; end
            OP_JNZF: begin w_step = zero_i ? 8'd1 : w_dist; w_back = 1'b0;    end
            OP_JNZB: begin w_step = zero_i ? 8'd1 : w_dist; w_back = !zero_i; end
            default: begin w_step = 8'd1;  w_back = 1'b0; end
        endcase
    end

    assign next_pc_o = w_back ? (pc_i - w_step) : (pc_i + w_step);

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter owner: fetch over req/ack, hold instruction,
//               apply next-PC requests, fetch timeout and halt handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00,
    parameter int              TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic [2:0]         exec_op,
    input  logic [3:0]         exec_off,
    input  logic               exec_zero,
    input  logic               halt_req,
    output logic [PC_W-1:0]    pc,
    output logic [CNT_W-1:0]   retired,
    output logic               halted,
    output logic               fault
);

    localparam int            TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t               state_q,   state_d;
    logic [PC_W-1:0]      pc_q,      pc_d;
    logic [INSTR_W-1:0]   instr_q,   instr_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic [TO_W-1:0]      tmo_q,     tmo_d;
    logic [PC_W-1:0]      w_next_pc;

    pc_next_calc u_next (
        .pc_i      (pc_q),
        .op_i      (exec_op_t'(exec_op)),
        .v_i       (exec_off),
        .zero_i    (exec_zero),
        .next_pc_o (w_next_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        tmo_d     = tmo_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                // An ack on the last allowed cycle still beats the timeout.
                if (imem_ack) begin
                    instr_d = imem_data;
                    tmo_d   = '0;
                    state_d = EXEC;
                end else if (tmo_q == TO_LAST) begin
                    state_d = FAULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    pc_d      = w_next_pc;
                    retired_d = retired_q + 16'd1;
                    state_d   = halt_req ? HALT : FETCH;
                end
            end
            HALT:    state_d = HALT;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == EXEC);
    assign pc          = pc_q;
    assign retired     = retired_q;
    assign halted      = (state_q == HALT);
    assign fault       = (state_q == FAULT);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer against a behavioural
//               next-PC model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam logic [7:0] RST_PC = 8'h10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [8:0]  imem_data;
    logic [8:0]  instr;
    logic        instr_valid;
    logic        exec_done;
    logic [2:0]  exec_op;
    logic [3:0]  exec_off;
    logic        exec_zero;
    logic        halt_req;
    logic [7:0]  pc;
    logic [15:0] retired;
    logic        halted;
    logic        fault;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  m_pc;
    logic [15:0] m_ret;

    pc_sequencer #(.RESET_PC(RST_PC), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .exec_op     (exec_op),
        .exec_off    (exec_off),
        .exec_zero   (exec_zero),
        .halt_req    (halt_req),
        .pc          (pc),
        .retired     (retired),
        .halted      (halted),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rule set: offset 2*v, untaken conditional branches step by one.
    function automatic logic [7:0] ref_next(input logic [7:0] p, input logic [2:0] op,
                                            input logic [3:0] v, input logic z);
        int pi;
        int off;
        int r;
        pi  = int'(p);
        off = 2 * int'(v);
        case (op)
            3'd0:    r = pi + 1;
            3'd1:    r = pi - 1;
            3'd2:    r = pi + off;
            3'd3:    r = pi - off;
            3'd4:    r = z  ? pi + off : pi + 1;
            3'd5:    r = z  ? pi - off : pi + 1;
            3'd6:    r = !z ? pi + off : pi + 1;
            default: r = !z ? pi - off : pi + 1;
        endcase
        r = ((r % 256) + 256) % 256;
        return 8'(r);
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = '0;
        exec_done = 1'b0;
        exec_op   = '0;
        exec_off  = '0;
        exec_zero = 1'b0;
        halt_req  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_pc  = RST_PC;
        m_ret = '0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full fetch/execute transaction with optional stall cycles on both handshakes.
    task automatic do_instr(input logic [2:0] op, input logic [3:0] v, input logic z,
                            input logic hlt, input int ack_dly, input int done_dly,
                            input logic [8:0] data);
        for (int i = 0; i < ack_dly; i++) begin
            total++;
            if (imem_req !== 1'b1 || fault !== 1'b0)
                begin bad++; $display("FAIL fetch_wait: req=%b fault=%b required req=1 fault=0", imem_req, fault); end
            @(negedge clk);
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc)
            begin bad++; $display("FAIL fetch_addr: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, m_pc); end
        imem_ack  = 1'b1;
        imem_data = data;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 9'($urandom);
        total++;
        if (instr_valid !== 1'b1 || instr !== data || imem_req !== 1'b0)
            begin bad++; $display("FAIL capture: valid=%b instr=%h req=%b required valid=1 instr=%h req=0", instr_valid, instr, imem_req, data); end
        for (int i = 0; i < done_dly; i++) begin
            halt_req  = 1'($urandom);
            exec_op   = 3'($urandom);
            exec_off  = 4'($urandom);
            exec_zero = 1'($urandom);
            @(negedge clk);
            total++;
            if (instr_valid !== 1'b1 || instr !== data || pc !== m_pc || halted !== 1'b0)
                begin bad++; $display("FAIL exec_hold: valid=%b instr=%h pc=%h halted=%b required 1 %h %h 0", instr_valid, instr, pc, halted, data, m_pc); end
        end
        exec_done = 1'b1;
        exec_op   = op;
        exec_off  = v;
        exec_zero = z;
        halt_req  = hlt;
        @(negedge clk);
        exec_done = 1'b0;
        halt_req  = 1'b0;
        m_pc  = ref_next(m_pc, op, v, z);
        m_ret = m_ret + 16'd1;
        total++;
        if (pc !== m_pc || retired !== m_ret)
            begin bad++; $display("FAIL retire: pc=%h retired=%0d required pc=%h retired=%0d (op=%0d v=%0d z=%b)", pc, retired, m_pc, m_ret, op, v, z); end
        total++;
        if (halted !== hlt || imem_req !== !hlt || instr_valid !== 1'b0)
            begin bad++; $display("FAIL next_state: halted=%b req=%b valid=%b required halted=%b req=%b valid=0", halted, imem_req, instr_valid, hlt, !hlt); end
    endtask

    task automatic goto_pc(input logic [7:0] target);
        logic [7:0] diff;
        logic [7:0] mag;
        int         guard;
        guard = 0;
        while (m_pc != target && guard < 40) begin
            diff = target - m_pc;
            if (diff < 8'd128) begin
                mag = diff;
                if (mag >= 8'd2) do_instr(OP_JF, (mag >= 8'd30) ? 4'd15 : 4'(mag >> 1), 1'b0, 1'b0, 0, 0, 9'($urandom));
                else             do_instr(OP_NEXT, 4'd0, 1'b0, 1'b0, 0, 0, 9'($urandom));
            end else begin
                mag = 8'd0 - diff;
                if (mag >= 8'd2) do_instr(OP_JB, (mag >= 8'd30) ? 4'd15 : 4'(mag >> 1), 1'b0, 1'b0, 0, 0, 9'($urandom));
                else             do_instr(OP_PREV, 4'd0, 1'b0, 1'b0, 0, 0, 9'($urandom));
            end
            guard++;
        end
        total++;
        if (pc !== target)
            begin bad++; $display("FAIL goto_pc: pc=%h required %h", pc, target); end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || fault !== 1'b0)
            begin bad++; $display("FAIL reset_flags: req=%b valid=%b halted=%b fault=%b required all 0", imem_req, instr_valid, halted, fault); end
        total++;
        if (pc !== RST_PC || imem_addr !== RST_PC || instr !== 9'h000 || retired !== 16'h0000)
            begin bad++; $display("FAIL reset_values: pc=%h addr=%h instr=%h retired=%h required 10 10 000 0000", pc, imem_addr, instr, retired); end
        repeat (3) @(negedge clk);
        total++;
        if (imem_req !== 1'b0)
            begin bad++; $display("FAIL idle_hold: req=%b required 0", imem_req); end
    endtask

    task automatic test_first_instr();
        start_run();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h10)
            begin bad++; $display("FAIL first_fetch: req=%b addr=%h required 1 10", imem_req, imem_addr); end
        do_instr(OP_NEXT, 4'd0, 1'b0, 1'b0, 0, 0, 9'h1A5);
        total++;
        if (pc !== 8'h11 || retired !== 16'd1 || instr !== 9'h1A5)
            begin bad++; $display("FAIL first_retire: pc=%h retired=%0d instr=%h required 11 1 1a5", pc, retired, instr); end
        start = 1'b1;
        do_instr(OP_NEXT, 4'd0, 1'b0, 1'b0, 0, 0, 9'h055);
        start = 1'b0;
    endtask

    task automatic test_jumps();
        goto_pc(8'h20);
        do_instr(OP_JF, 4'd5, 1'b0, 1'b0, 1, 0, 9'($urandom));
        total++;
        if (pc !== 8'h2A) begin bad++; $display("FAIL jf: pc=%h required 2a", pc); end
        do_instr(OP_JB, 4'd15, 1'b1, 1'b0, 0, 1, 9'($urandom));
        total++;
        if (pc !== 8'h0C) begin bad++; $display("FAIL jb: pc=%h required 0c", pc); end
        goto_pc(8'h30);
        do_instr(OP_JZF, 4'd3, 1'b1, 1'b0, 0, 0, 9'($urandom));
        total++;
        if (pc !== 8'h36) begin bad++; $display("FAIL jzf_taken: pc=%h required 36", pc); end
        goto_pc(8'h30);
        do_instr(OP_JZF, 4'd3, 1'b0, 1'b0, 0, 0, 9'($urandom));
        total++;
        if (pc !== 8'h31) begin bad++; $display("FAIL jzf_not_taken: pc=%h required 31", pc); end
        goto_pc(8'h30);
        do_instr(OP_JNZB, 4'd1, 1'b0, 1'b0, 0, 0, 9'($urandom));
        total++;
        if (pc !== 8'h2E) begin bad++; $display("FAIL jnzb_taken: pc=%h required 2e", pc); end
        do_instr(OP_JF, 4'd0, 1'b0, 1'b0, 0, 0, 9'($urandom));
        total++;
        if (pc !== 8'h2E) begin bad++; $display("FAIL jump_zero_offset: pc=%h required 2e", pc); end
    endtask

    task automatic test_wrap();
        goto_pc(8'hFF);
        do_instr(OP_NEXT, 4'd0, 1'b0, 1'b0, 0, 0, 9'($urandom));
        total++;
        if (pc !== 8'h00) begin bad++; $display("FAIL wrap_next: pc=%h required 00", pc); end
        goto_pc(8'h02);
        do_instr(OP_JB, 4'd2, 1'b0, 1'b0, 0, 0, 9'($urandom));
        total++;
        if (pc !== 8'hFE) begin bad++; $display("FAIL wrap_jb: pc=%h required fe", pc); end
        goto_pc(8'h00);
        do_instr(OP_PREV, 4'd0, 1'b0, 1'b0, 0, 0, 9'($urandom));
        total++;
        if (pc !== 8'hFF) begin bad++; $display("FAIL wrap_prev: pc=%h required ff", pc); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++)
            do_instr(3'($urandom), 4'($urandom), 1'($urandom), 1'b0,
                     int'($urandom_range(4, 0)), int'($urandom_range(3, 0)), 9'($urandom));
    endtask

    task automatic test_timeout();
        do_reset();
        start_run();
        do_instr(OP_JF, 4'd3, 1'b0, 1'b0, 0, 0, 9'($urandom));
        repeat (14) @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || fault !== 1'b0)
            begin bad++; $display("FAIL timeout_early: req=%b fault=%b required 1 0", imem_req, fault); end
        @(negedge clk);
        total++;
        if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== m_pc)
            begin bad++; $display("FAIL timeout_fault: fault=%b req=%b pc=%h required 1 0 %h", fault, imem_req, pc, m_pc); end
        imem_ack  = 1'b1;
        exec_done = 1'b1;
        start     = 1'b1;
        repeat (4) @(negedge clk);
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        start     = 1'b0;
        total++;
        if (fault !== 1'b1 || pc !== m_pc || instr_valid !== 1'b0 || retired !== m_ret)
            begin bad++; $display("FAIL fault_sticky: fault=%b pc=%h valid=%b retired=%0d required 1 %h 0 %0d", fault, pc, instr_valid, retired, m_pc, m_ret); end
    endtask

    task automatic test_ack_at_limit();
        do_reset();
        start_run();
        do_instr(OP_NEXT, 4'd0, 1'b0, 1'b0, 14, 0, 9'($urandom));
        total++;
        if (fault !== 1'b0) begin bad++; $display("FAIL ack_at_limit: fault=%b required 0", fault); end
        do_instr(OP_JZB, 4'd2, 1'b1, 1'b0, 14, 0, 9'($urandom));
    endtask

    task automatic test_halt();
        do_reset();
        start_run();
        do_instr(OP_JF, 4'd7, 1'b0, 1'b0, 0, 2, 9'($urandom));
        do_instr(OP_JNZF, 4'd4, 1'b0, 1'b1, 1, 0, 9'($urandom));
        start    = 1'b1;
        imem_ack = 1'b1;
        repeat (5) @(negedge clk);
        start    = 1'b0;
        imem_ack = 1'b0;
        total++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== m_pc || retired !== m_ret)
            begin bad++; $display("FAIL halt_frozen: halted=%b req=%b pc=%h retired=%0d required 1 0 %h %0d", halted, imem_req, pc, retired, m_pc, m_ret); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        start_run();
        do_instr(OP_JF, 4'd9, 1'b0, 1'b0, 0, 0, 9'($urandom));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || pc !== RST_PC || retired !== 16'd0 || instr !== 9'h000)
            begin bad++; $display("FAIL reset_mid_fetch: req=%b pc=%h retired=%0d instr=%h required 0 10 0 000", imem_req, pc, retired, instr); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_instr();
        test_jumps();
        test_wrap();
        test_random();
        test_timeout();
        test_ack_at_limit();
        test_halt();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the 8-bit program counter of the 9-bit CPU.
- Fetches instructions from instruction memory over a req/ack handshake and holds each instruction for the execute stage.
- On completion it takes back a next-PC request (step, step back, conditional or unconditional short jump) and updates the PC.
- It is the PC-side consumer of the increment/decrement/jump control encoding.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- TIMEOUT, 15, maximum FETCH cycles without imem_ack before fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  leave IDLE and begin fetching at pc.
- imem_req  out  1  fetch request.
- imem_addr  out  8  fetch address; always equals pc.
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  9  fetched instruction.
- instr  out  9  held instruction.
- instr_valid  out  1  instr is valid for execute.
- exec_done  in  1  execute has finished instr; op/offset/zero are valid.
- exec_op  in  3  next-PC operation (see package).
- exec_off  in  4  jump magnitude v.
- exec_zero  in  1  zero flag of the tested register.
- halt_req  in  1  stop after the current completion.
- pc  out  8  current program counter.
- retired  out  16  completed-instruction count; wraps modulo 2^16.
- halted  out  1  in HALT.
- fault  out  1  fetch timeout; sticky until reset.

Behaviour:
- Reset on rst_n=0 at a clk edge, regardless of state:
  - state=IDLE, pc=RESET_PC, instr=0, retired=0, timeout counter=0.
  - imem_req, instr_valid, halted and fault are all 0.
- States: IDLE, FETCH, EXEC, HALT, FAULT.
- IDLE: outputs inactive. start=1 moves to FETCH. start is ignored in every other state.
- FETCH:
  - imem_req=1 and imem_addr=pc, decoded from state.
  - imem_ack=1: capture imem_data into instr, go to EXEC, clear the counter.
  - Otherwise the counter increments. Reaching TIMEOUT with no ack goes to FAULT.
  - An ack in the same cycle the counter reaches TIMEOUT wins.
- EXEC:
  - instr_valid=1, instr stable.
  - exec_done=1: pc <= next_pc, retired increments.
  - Then go to HALT if halt_req=1 in the same cycle, else to FETCH.
  - halt_req without exec_done is ignored.
- HALT: halted=1, pc frozen. Exits only by reset.
- FAULT: fault=1, imem_req=0, pc frozen. Exits only by reset.
- Minimum throughput is 2 cycles per instruction (ack on the first FETCH cycle, done on the first EXEC cycle).
- next_pc, with d = {3'b000, v, 1'b0} (offset = 2*v, range 0..30):
  - OP_NEXT: pc+1.
  - OP_PREV: pc-1.
  - OP_JF: pc+d.
  - OP_JB: pc-d.
  - OP_JZF / OP_JZB: pc±d if exec_zero=1, else pc+1.
  - OP_JNZF / OP_JNZB: pc±d if exec_zero=0, else pc+1.
- All PC arithmetic is modulo 256 and wraps silently: 8'hFF+1 = 8'h00, 8'h00-1 = 8'hFF.
- v=0 on a taken jump leaves pc unchanged; this is legal.
- A new instruction always comes from a fresh FETCH. No prefetch, no buffering beyond instr.

Decomposition:
- Package pc_seq_pkg holds:
  - typedef enum logic[2:0] exec_op_t: OP_NEXT=0, OP_PREV=1, OP_JF=2, OP_JB=3, OP_JZF=4, OP_JZB=5, OP_JNZF=6, OP_JNZB=7.
  - typedef enum state_t: IDLE, FETCH, EXEC, HALT, FAULT.
  - Widths: PC_W=8, INSTR_W=9, CNT_W=16.
- One combinational sub-module, pc_next_calc (pc, op, v, zero -> next_pc), holds all offset and add/sub logic.

Test Plan:
- Reset with RESET_PC=8'h10, start, ack at once with imem_data=9'h1A5, exec_done OP_NEXT -> imem_addr=8'h10, instr=9'h1A5, pc=8'h11, retired=1, 2 cycles per instruction.
- pc=8'h20, OP_JF v=4'd5 -> pc=8'h2A; then OP_JB v=4'd15 -> pc=8'h0C.
- pc=8'h30: OP_JZF v=3 with zero=1 -> 8'h36; OP_JZF zero=0 -> 8'h31; OP_JNZB v=1 zero=0 -> 8'h2E.
- Wrap: pc=8'hFF with OP_NEXT -> 8'h00; pc=8'h02 with OP_JB v=2 -> 8'hFE; pc=8'h00 with OP_PREV -> 8'hFF.
- No ack for 15 FETCH cycles -> fault=1, imem_req=0, pc unchanged. An ack on cycle 15 is accepted instead, with no fault.
- exec_done and halt_req together -> pc updated once, halted=1, no further imem_req. rst_n=0 mid-FETCH -> imem_req=0 and pc=RESET_PC after the next edge.
